// File: rtl/ssi_pkg.sv
// Shared types and helpers for the SSI encoder read path.
//   ssi_state_t : read-controller state encoding
//   gray2bin    : Gray-to-binary conversion of the low `width` bits of a word
//                 (width 1..32; bits above `width` return 0)
package ssi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    DONE,
    RECOVER
  } ssi_state_t;

  localparam int unsigned GRAY_MAX_W = 32;

  // Running XOR from the MSB down: bin[i] = bin[i+1] ^ g[i].
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(
    input logic [GRAY_MAX_W-1:0] g,
    input int unsigned           width
  );
    logic [GRAY_MAX_W-1:0] b;
    logic                  acc;
    logic [4:0]            idx;
    b   = '0;
    acc = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < GRAY_MAX_W; k++) begin
      if (k < width) begin
        idx    = 5'(width - 1 - k);
        acc    = acc ^ g[idx];
        b[idx] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk, rst  : destination clock, synchronous active-high reset
//   d         : asynchronous input
//   q         : synchronized output (RESET_VAL while in reset)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ssi_read_controller.sv
// SSI absolute-encoder read controller.
// Merges front-panel trigger pulses and a periodic auto-read tick into one
// pending request, runs an SSI transfer (clock generation, MSB-first shift-in,
// optional Gray decode) and enforces the encoder monoflop recovery time.
//   clk, rst    : system clock, synchronous active-high reset
//   trig_pulse  : one-cycle read request
//   auto_en     : enables the periodic auto-read timer
//   ssi_data    : asynchronous encoder data (synchronized internally)
//   ssi_clk     : SSI clock to the encoder, idles high
//   pos         : last valid position, held between reads
//   pos_valid   : one-cycle strobe when pos updates
//   busy        : high whenever the controller is not idle
//   err         : one-cycle pulse when the data line is low at transfer start
//   overrun     : one-cycle pulse when a request is dropped
module ssi_read_controller
  import ssi_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 13,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned MONO_CYCLES = 100,
  parameter int unsigned AUTO_PERIOD = 1000,
  parameter bit          GRAY_CODE   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig_pulse,
  input  logic                 auto_en,
  input  logic                 ssi_data,
  output logic                 ssi_clk,
  output logic [DATA_BITS-1:0] pos,
  output logic                 pos_valid,
  output logic                 busy,
  output logic                 err,
  output logic                 overrun
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned MW = (MONO_CYCLES > 1) ? $clog2(MONO_CYCLES) : 1;
  localparam int unsigned TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  ssi_state_t           state, state_next;
  logic                 data_s;
  logic [DW-1:0]        div_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [MW-1:0]        mono_cnt;
  logic [TW-1:0]        timer;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] pos_word;
  logic                 pending;
  logic                 timer_tick, req;
  logic                 div_last, mono_last;
  logic                 consume, sample, pos_load, err_next, clk_next;

  // Idle encoder line is high; resetting the synchronizer to 1 avoids a
  // spurious err on a request made right after reset.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ssi_data),
    .q   (data_s)
  );

  assign timer_tick = (AUTO_PERIOD != 0) && auto_en && (timer == TW'(AUTO_PERIOD - 1));
  assign req        = trig_pulse | timer_tick;
  assign div_last   = (div_cnt == DW'(CLK_DIV - 1));
  assign mono_last  = (mono_cnt == MW'(MONO_CYCLES - 1));
  assign busy       = (state != IDLE);
  assign pos_word   = GRAY_CODE ? DATA_BITS'(gray2bin(32'(shreg), DATA_BITS)) : shreg;

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    sample     = 1'b0;
    pos_load   = 1'b0;
    err_next   = 1'b0;
    clk_next   = ssi_clk;
    case (state)
      IDLE: begin
        if (pending) begin
          consume = 1'b1;
          if (data_s) begin
            clk_next   = 1'b0;
            state_next = START;
          end else begin
            err_next   = 1'b1;
            state_next = RECOVER;
          end
        end
      end
      START: begin
        if (div_last) begin
          clk_next   = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (div_last) begin
          if (ssi_clk) begin
            clk_next = 1'b0;
            sample   = 1'b1;
          end else begin
            // The rise after the last sample's low half-period ends the word.
            clk_next = 1'b1;
            if (bit_cnt == BW'(DATA_BITS)) state_next = DONE;
          end
        end
      end
      DONE: begin
        pos_load   = 1'b1;
        state_next = RECOVER;
      end
      RECOVER: begin
        if (mono_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ssi_clk   <= 1'b1;
      pos       <= '0;
      pos_valid <= 1'b0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      pending   <= 1'b0;
      timer     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      mono_cnt  <= '0;
      shreg     <= '0;
    end else begin
      state     <= state_next;
      ssi_clk   <= clk_next;
      err       <= err_next;
      pos_valid <= pos_load;
      if (pos_load) pos <= pos_word;

      // A request on the consuming edge re-arms pending rather than being lost.
      if (consume)  pending <= req;
      else if (req) pending <= 1'b1;
      overrun <= req && pending && !consume;

      if (AUTO_PERIOD == 0 || !auto_en || timer_tick) timer <= '0;
      else                                            timer <= timer + 1'b1;

      if ((state == START || state == SHIFT) && !div_last) div_cnt <= div_cnt + 1'b1;
      else                                                 div_cnt <= '0;

      if (state == IDLE) bit_cnt <= '0;
      else if (sample)   bit_cnt <= bit_cnt + 1'b1;

      if (sample) shreg <= {shreg[DATA_BITS-2:0], data_s};

      if (state == RECOVER && !mono_last) mono_cnt <= mono_cnt + 1'b1;
      else                                mono_cnt <= '0;
    end
  end

endmodule

// File: doc/ssi_read_controller.md
# ssi_read_controller

Sequences absolute-encoder reads over a Synchronous Serial Interface (SSI) and arbitrates between two read requesters: the one-cycle pulse from the front-panel debounce/pulse stage and an internal periodic auto-read timer. It generates the SSI clock and shifts in `DATA_BITS` bits MSB-first, with optional Gray-to-binary conversion. It presents each completed position with a one-cycle valid strobe and enforces the encoder's monoflop recovery time between transfers. It sits between the button conditioning logic and the position display/consumer logic of the SSI controller.

## Interface
- `DATA_BITS`, 13: encoder word width, 2..32.
- `CLK_DIV`, 4: `clk` cycles per SSI clock half-period, ≥4.
- `MONO_CYCLES`, 100: `clk` cycles `ssi_clk` is held high after a transfer (monoflop recovery), ≥1.
- `AUTO_PERIOD`, 1000: auto-read interval in `clk` cycles. 0 disables the timer.
- `GRAY_CODE`, 1: 1 = convert the received Gray word to binary; 0 = pass through.
- `clk` in 1: system clock. The block uses one clock.
- `rst` in 1: synchronous, active-high reset.
- `trig_pulse` in 1: one-cycle read request from the debounce/pulse stage.
- `auto_en` in 1: enables the auto-read timer requester.
- `ssi_data` in 1: encoder serial data, asynchronous. Passes through an internal 2-flop synchronizer.
- `ssi_clk` out 1: SSI clock to the encoder. Idles high.
- `pos` out `DATA_BITS`: last valid position. Holds its value between reads.
- `pos_valid` out 1: one-cycle strobe when `pos` updates.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle pulse when the encoder line is low at transfer start.
- `overrun` out 1: one-cycle pulse when a request is dropped.

## Operation
- Requests:
  - `trig_pulse` and the timer tick both OR into one `pending` bit.
  - Simultaneous requests merge into a single transfer and do not raise `overrun`.
  - A request arriving while `pending` is already set is dropped and pulses `overrun`.
- Timer:
  - Free-running counter 0..`AUTO_PERIOD`-1. It ticks when wrapping to 0.
  - Held at 0 while `auto_en`=0 or `AUTO_PERIOD`=0.
- State machine: IDLE, START, SHIFT, DONE, RECOVER.
  - IDLE, `pending`=1, synchronized `ssi_data`=1: clear `pending`, drive `ssi_clk` low, go to START.
  - IDLE, `pending`=1, synchronized `ssi_data`=0: clear `pending`, pulse `err`, go to RECOVER. `ssi_clk` does not toggle.
  - START: one low half-period (encoder latch edge), then `ssi_clk` rises and the block goes to SHIFT.
  - SHIFT: `ssi_clk` toggles every `CLK_DIV` cycles. On each falling edge, the synchronized `ssi_data` shifts into the LSB of the shift register (MSB-first overall). After `DATA_BITS` samples, `ssi_clk` stays low one more half-period, then rises and the block goes to DONE.
  - DONE: 1 cycle. Latch `pos` (Gray-converted when `GRAY_CODE`=1), pulse `pos_valid`, go to RECOVER.
  - RECOVER: `ssi_clk` high for `MONO_CYCLES` cycles, then go to IDLE. Requests arriving here or earlier set `pending` and are serviced from IDLE.
- Gray conversion: `bin[N-1] = g[N-1]`; `bin[i] = bin[i+1] ^ g[i]`.

## Timing
- Reset values: `ssi_clk`=1; `pos`=0; `pos_valid`, `busy`, `err`, `overrun`=0; `pending`=0; timer=0; state=IDLE.
- Request in IDLE at cycle t (registered `trig_pulse`): `ssi_clk` low at t+1, `busy`=1 from t+1.
- Transfer waveform: `2·DATA_BITS+1` half-periods from t+1. The final rise is at t+1+(2·DATA_BITS+1)·`CLK_DIV`.
- `pos_valid` asserts at t+2+(2·DATA_BITS+1)·`CLK_DIV`.
- `busy` falls `MONO_CYCLES` cycles after the DONE cycle.
- Sampling: at the cycle `ssi_clk` is driven low, the sampled value is the 2-flop-synchronized `ssi_data`. `CLK_DIV`≥4 guarantees settling.
- Back-to-back: a request pending at RECOVER exit starts the next transfer in the first IDLE cycle.
- `rst` mid-transfer: next cycle `ssi_clk`=1, state=IDLE, `pending` cleared, `pos` cleared. No `pos_valid`.

## Structure
- Shared package `ssi_pkg`:
  - `ssi_state_t` enum (IDLE, START, SHIFT, DONE, RECOVER).
  - `gray2bin` function parameterized by width.
- Sub-module `sync_2ff` for `ssi_data` (reusable for other asynchronous inputs).
- Everything else lives in `ssi_read_controller`: divider counter, bit counter, shift register, timer, `pending`.

## Test plan
- Defaults, encoder model returns Gray `13'h1A2B`; pulse `trig_pulse` at cycle 10 → `ssi_clk` low at 11; exactly 14 falling edges; `pos_valid` at cycle 120 with `pos` = gray2bin(`13'h1A2B`); `busy` low at cycle 220.
- `GRAY_CODE`=0, word `13'h0001` then `13'h1FFF` back-to-back → `pos` equals the raw words, one `pos_valid` each.
- `ssi_data` held 0, trigger → `err` pulse one cycle after the request, `ssi_clk` never toggles, `busy` for 100 cycles, no `pos_valid`.
- `auto_en`=1, `AUTO_PERIOD`=300, `trig_pulse` on the same cycle as a timer tick → one transfer, no `overrun`; two further triggers during SHIFT → one queued transfer plus one `overrun` pulse.
- `rst` asserted during SHIFT bit 5 → next cycle `ssi_clk`=1, `busy`=0, `pos`=0; a fresh trigger then completes normally.
- `AUTO_PERIOD`=0 with `auto_en`=1 → no transfers over 5000 cycles without `trig_pulse`.
